tag_channel_filter: RTL and testbench

- Pipelined AXI-Stream stage directly upstream of the measurement stage.
- Masks out tags from disabled channels by clearing their tkeep lanes, and drops words that end up with no valid lanes.
- Keeps saturating pass/drop tag counters.
- Contains a 2-entry skid buffer (output register plus skid register), so backpressure from the measurement stage never loses a word.

---
 rtl/tag_channel_filter.sv | 196 +++++++++++++++++++
 tb/tb_tag_channel_filter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tag_channel_filter.sv
// tag_channel_filter
//   Pipelined AXI-Stream stage placed in front of the measurement stage.
//   Each accepted word has its tkeep lanes masked by the per-channel enable
//   mask. Words whose filtered tkeep is empty are consumed without being
//   stored. Non-empty words pass through a 2-entry skid buffer, which is an
//   output register plus a skid register. Saturating counters track how many
//   tags were forwarded and how many were masked out.
//
// Ports
//   clk, rst          : stream clock, synchronous active-high reset
//   s_axis_*          : upstream word (tvalid/tready/tkeep/channel/tagtime)
//   m_axis_*          : filtered word towards the measurement stage
//   channel_mask_i    : bit c = 1 enables channel c (used in the accept cycle)
//   clear_counters_i  : synchronous clear of both counters
//   tags_passed_o     : saturating count of forwarded tags
//   tags_dropped_o    : saturating count of masked-out tags
module tag_channel_filter #(
  parameter int WORD_WIDTH    = 4,
  parameter int TIME_WIDTH    = 64,
  parameter int CHANNEL_WIDTH = 6,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  input  logic [WORD_WIDTH-1:0]               s_axis_tkeep,
  input  logic [CHANNEL_WIDTH*WORD_WIDTH-1:0] s_axis_channel,
  input  logic [TIME_WIDTH*WORD_WIDTH-1:0]    s_axis_tagtime,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic [WORD_WIDTH-1:0]               m_axis_tkeep,
  output logic [CHANNEL_WIDTH*WORD_WIDTH-1:0] m_axis_channel,
  output logic [TIME_WIDTH*WORD_WIDTH-1:0]    m_axis_tagtime,
  input  logic [2**CHANNEL_WIDTH-1:0]         channel_mask_i,
  input  logic                                clear_counters_i,
  output logic [CNT_WIDTH-1:0]                tags_passed_o,
  output logic [CNT_WIDTH-1:0]                tags_dropped_o
);

  localparam int CW  = CHANNEL_WIDTH * WORD_WIDTH;
  localparam int TW  = TIME_WIDTH * WORD_WIDTH;
  localparam int PCW = $clog2(WORD_WIDTH + 1);

  // Number of set bits in a lane-valid vector
  function automatic logic [PCW-1:0] popcount(input logic [WORD_WIDTH-1:0] v);
    logic [PCW-1:0] cnt;
    cnt = {PCW{1'b0}};
    for (int i = 0; i < WORD_WIDTH; i++) begin
      cnt = cnt + PCW'(v[i]);
    end
    return cnt;
  endfunction

  // Add a small increment to a counter; the result sticks at all-ones
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [PCW-1:0]       b);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, a} + (CNT_WIDTH + 1)'(b);
    if (sum[CNT_WIDTH]) begin
      return {CNT_WIDTH{1'b1}};
    end else begin
      return sum[CNT_WIDTH-1:0];
    end
  endfunction

  // Output register, skid register, ready and counters
  logic                  r_out_valid, r_skid_valid, r_ready;
  logic [WORD_WIDTH-1:0] r_out_keep, r_skid_keep;
  logic [CW-1:0]         r_out_chan, r_skid_chan;
  logic [TW-1:0]         r_out_time, r_skid_time;
  logic [CNT_WIDTH-1:0]  r_passed, r_dropped;

  logic                  w_out_valid_n, w_skid_valid_n, w_ready_n;
  logic [WORD_WIDTH-1:0] w_out_keep_n, w_skid_keep_n;
  logic [CW-1:0]         w_out_chan_n, w_skid_chan_n;
  logic [TW-1:0]         w_out_time_n, w_skid_time_n;
  logic [CNT_WIDTH-1:0]  w_passed_n, w_dropped_n;

  logic                  w_accept, w_store, w_out_free;
  logic [WORD_WIDTH-1:0] w_keep_f;
  logic [PCW-1:0]        w_pass_inc, w_drop_inc;

  assign w_accept   = s_axis_tvalid & r_ready;
  assign w_store    = w_accept & (|w_keep_f);
  // The output register can take a word when it is empty or being drained now
  assign w_out_free = ~r_out_valid | m_axis_tready;

  // Lane filter: each lane's tkeep is gated by the enable bit of its channel
  always_comb begin
    w_keep_f = {WORD_WIDTH{1'b0}};
    for (int i = 0; i < WORD_WIDTH; i++) begin
      w_keep_f[i] = s_axis_tkeep[i] &
                    channel_mask_i[s_axis_channel[i*CHANNEL_WIDTH +: CHANNEL_WIDTH]];
    end
  end

  // Skid buffer next state: refill the output from skid first, then from input
  always_comb begin
    w_out_valid_n  = r_out_valid;
    w_out_keep_n   = r_out_keep;
    w_out_chan_n   = r_out_chan;
    w_out_time_n   = r_out_time;
    w_skid_valid_n = r_skid_valid;
    w_skid_keep_n  = r_skid_keep;
    w_skid_chan_n  = r_skid_chan;
    w_skid_time_n  = r_skid_time;
    if (w_out_free) begin
      if (r_skid_valid) begin
        // The skid word is older, so it moves up first. A new word only
        // arrives here if ready was high, and it then refills the skid.
        w_out_valid_n  = 1'b1;
        w_out_keep_n   = r_skid_keep;
        w_out_chan_n   = r_skid_chan;
        w_out_time_n   = r_skid_time;
        w_skid_valid_n = w_store;
        w_skid_keep_n  = w_store ? w_keep_f : r_skid_keep;
        w_skid_chan_n  = w_store ? s_axis_channel : r_skid_chan;
        w_skid_time_n  = w_store ? s_axis_tagtime : r_skid_time;
      end else if (w_store) begin
        w_out_valid_n = 1'b1;
        w_out_keep_n  = w_keep_f;
        w_out_chan_n  = s_axis_channel;
        w_out_time_n  = s_axis_tagtime;
      end else begin
        // Payload is left as is; it is only meaningful while tvalid is high
        w_out_valid_n = 1'b0;
      end
    end else begin
      if (w_store) begin
        w_skid_valid_n = 1'b1;
        w_skid_keep_n  = w_keep_f;
        w_skid_chan_n  = s_axis_channel;
        w_skid_time_n  = s_axis_tagtime;
      end else begin
        w_skid_valid_n = r_skid_valid;
      end
    end
    // Ready is registered: it follows skid occupancy one edge later
    w_ready_n = ~w_skid_valid_n;
  end

  // Counter next state: a clear overrides any increment in the same cycle
  always_comb begin
    w_pass_inc = popcount(w_keep_f);
    w_drop_inc = popcount(s_axis_tkeep & ~w_keep_f);
    if (clear_counters_i) begin
      w_passed_n  = {CNT_WIDTH{1'b0}};
      w_dropped_n = {CNT_WIDTH{1'b0}};
    end else if (w_accept) begin
      w_passed_n  = sat_add(r_passed, w_pass_inc);
      w_dropped_n = sat_add(r_dropped, w_drop_inc);
    end else begin
      w_passed_n  = r_passed;
      w_dropped_n = r_dropped;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_keep   <= {WORD_WIDTH{1'b0}};
      r_out_chan   <= {CW{1'b0}};
      r_out_time   <= {TW{1'b0}};
      r_skid_valid <= 1'b0;
      r_skid_keep  <= {WORD_WIDTH{1'b0}};
      r_skid_chan  <= {CW{1'b0}};
      r_skid_time  <= {TW{1'b0}};
      r_ready      <= 1'b0;
      r_passed     <= {CNT_WIDTH{1'b0}};
      r_dropped    <= {CNT_WIDTH{1'b0}};
    end else begin
      r_out_valid  <= w_out_valid_n;
      r_out_keep   <= w_out_keep_n;
      r_out_chan   <= w_out_chan_n;
      r_out_time   <= w_out_time_n;
      r_skid_valid <= w_skid_valid_n;
      r_skid_keep  <= w_skid_keep_n;
      r_skid_chan  <= w_skid_chan_n;
      r_skid_time  <= w_skid_time_n;
      r_ready      <= w_ready_n;
      r_passed     <= w_passed_n;
      r_dropped    <= w_dropped_n;
    end
  end

  assign s_axis_tready  = r_ready;
  assign m_axis_tvalid  = r_out_valid;
  assign m_axis_tkeep   = r_out_keep;
  assign m_axis_channel = r_out_chan;
  assign m_axis_tagtime = r_out_time;
  assign tags_passed_o  = r_passed;
  assign tags_dropped_o = r_dropped;

endmodule

// File: tb/tb_tag_channel_filter.sv
module tb_tag_channel_filter;

  localparam int WW  = 4;
  localparam int TWD = 64;
  localparam int CHW = 6;
  localparam int CNW = 6;   // small counters so saturation (63) is reachable

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid, s_ready, m_valid, m_ready, clr;
  logic [WW-1:0]    s_keep, m_keep;
  logic [CHW*WW-1:0] s_chan, m_chan;
  logic [TWD*WW-1:0] s_time, m_time;
  logic [63:0]      mask;
  logic [CNW-1:0]   passed, dropped;

  int total = 0;
  int bad   = 0;

  tag_channel_filter #(
    .WORD_WIDTH(WW), .TIME_WIDTH(TWD), .CHANNEL_WIDTH(CHW), .CNT_WIDTH(CNW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tkeep(s_keep),
    .s_axis_channel(s_chan), .s_axis_tagtime(s_time),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tkeep(m_keep),
    .m_axis_channel(m_chan), .m_axis_tagtime(m_time),
    .channel_mask_i(mask), .clear_counters_i(clr),
    .tags_passed_o(passed), .tags_dropped_o(dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] mask;
    logic [23:0] chans;
    logic [3:0]  tkeep;
    logic        exp_valid;
    logic [3:0]  exp_keep;
    int          exp_pass;
    int          exp_drop;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] ch4(input int c3, input int c2, input int c1, input int c0);
    return {6'(c3), 6'(c2), 6'(c1), 6'(c0)};
  endfunction

  function automatic logic [255:0] mk_time(input int k);
    return {64'(k + 3) << 32, 64'(k + 2) << 16, 64'(k + 1) << 8, 64'(k)};
  endfunction

  task automatic drive(input logic v, input logic [3:0] k, input logic [23:0] c, input logic [255:0] t);
    s_valid = v;
    s_keep  = k;
    s_chan  = c;
    s_time  = t;
  endtask

  initial begin
    int rp;
    int rd;

    //               mask                    chans            tkeep  v     keep   p  d
    vecs[0] = '{64'h5,                  ch4(3, 2, 1, 0),   4'b1111, 1'b1, 4'b0101, 2, 2};
    vecs[1] = '{64'h5,                  ch4(3, 3, 1, 1),   4'b1111, 1'b0, 4'b0000, 0, 4};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, ch4(1, 2, 3, 4),   4'b0000, 1'b0, 4'b0000, 0, 0};
    vecs[3] = '{64'h8000_0000_0000_0000, ch4(63, 0, 63, 5), 4'b1011, 1'b1, 4'b1010, 2, 1};
    vecs[4] = '{64'h0000_0000_0010_0400, ch4(20, 10, 20, 11), 4'b1110, 1'b1, 4'b1110, 3, 0};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, ch4(9, 9, 9, 9),   4'b0001, 1'b1, 4'b0001, 1, 0};

    rst = 1'b1; m_ready = 1'b1; clr = 1'b0; mask = 64'd0;
    drive(1'b0, 4'd0, 24'd0, 256'd0);
    tick(); tick();
    chk("rst_mvalid", 256'(m_valid), 256'd0);
    chk("rst_sready", 256'(s_ready), 256'd0);
    chk("rst_passed", 256'(passed), 256'd0);
    chk("rst_dropped", 256'(dropped), 256'd0);
    chk("rst_mkeep", 256'(m_keep), 256'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", 256'(s_ready), 256'd1);

    // Pass-through, back-to-back
    mask = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 4'b1111, ch4(3, 2, 1, 0), mk_time(k));
      tick();
      chk("pt_valid", 256'(m_valid), 256'd1);
      chk("pt_time", m_time, mk_time(k));
      chk("pt_keep", 256'(m_keep), 256'hF);
      chk("pt_ready", 256'(s_ready), 256'd1);
    end
    drive(1'b0, 4'd0, 24'd0, 256'd0);
    tick();
    chk("pt_idle", 256'(m_valid), 256'd0);
    chk("pt_passed", 256'(passed), 256'd32);
    chk("pt_dropped", 256'(dropped), 256'd0);

    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_passed", 256'(passed), 256'd0);
    chk("clr_dropped", 256'(dropped), 256'd0);

    // Table: masking, full drop, empty tkeep, mask change per word
    rp = 0; rd = 0;
    for (int i = 0; i < 6; i++) begin
      mask = vecs[i].mask;
      drive(1'b1, vecs[i].tkeep, vecs[i].chans, mk_time(100 + i));
      tick();
      rp += vecs[i].exp_pass;
      rd += vecs[i].exp_drop;
      chk($sformatf("vec%0d_valid", i), 256'(m_valid), 256'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_keep", i), 256'(m_keep), 256'(vecs[i].exp_keep));
        chk($sformatf("vec%0d_time", i), m_time, mk_time(100 + i));
        chk($sformatf("vec%0d_chan", i), 256'(m_chan), 256'(vecs[i].chans));
      end
      chk($sformatf("vec%0d_passed", i), 256'(passed), 256'(rp));
      chk($sformatf("vec%0d_dropped", i), 256'(dropped), 256'(rd));
    end
    drive(1'b0, 4'd0, 24'd0, 256'd0);
    tick();

    // Backpressure: A in output, B in skid, C waits
    mask = 64'hFFFF_FFFF_FFFF_FFFF;
    m_ready = 1'b0;
    drive(1'b1, 4'b1111, ch4(1, 1, 1, 1), mk_time(200));
    tick();
    chk("bp_A_valid", 256'(m_valid), 256'd1);
    chk("bp_A_time", m_time, mk_time(200));
    chk("bp_A_ready", 256'(s_ready), 256'd1);
    drive(1'b1, 4'b1111, ch4(2, 2, 2, 2), mk_time(300));
    tick();
    chk("bp_B_hold", m_time, mk_time(200));
    chk("bp_B_ready", 256'(s_ready), 256'd0);
    drive(1'b1, 4'b1111, ch4(4, 4, 4, 4), mk_time(400));
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("bp_stall_valid", 256'(m_valid), 256'd1);
      chk("bp_stall_time", m_time, mk_time(200));
      chk("bp_stall_chan", 256'(m_chan), 256'(ch4(1, 1, 1, 1)));
      chk("bp_stall_ready", 256'(s_ready), 256'd0);
    end
    m_ready = 1'b1;
    tick();
    chk("bp_B_out", m_time, mk_time(300));
    chk("bp_ready_back", 256'(s_ready), 256'd1);
    tick();
    chk("bp_C_out", m_time, mk_time(400));
    chk("bp_C_valid", 256'(m_valid), 256'd1);
    drive(1'b0, 4'd0, 24'd0, 256'd0);
    tick();
    chk("bp_empty", 256'(m_valid), 256'd0);
    chk("bp_passed", 256'(passed), 256'(rp + 12));

    // Clear in the same cycle as an accepted word
    clr = 1'b1;
    drive(1'b1, 4'b1111, ch4(0, 0, 0, 0), mk_time(500));
    tick();
    chk("clr_acc_passed", 256'(passed), 256'd0);
    chk("clr_acc_dropped", 256'(dropped), 256'd0);
    chk("clr_acc_word", m_time, mk_time(500));
    clr = 1'b0;
    drive(1'b0, 4'd0, 24'd0, 256'd0);
    tick();
    chk("clr_acc_after", 256'(passed), 256'd0);

    // Saturation at 63
    for (int k = 0; k < 15; k++) begin
      drive(1'b1, 4'b1111, ch4(5, 6, 7, 8), mk_time(600 + k));
      tick();
    end
    chk("sat_60", 256'(passed), 256'd60);
    tick();
    chk("sat_63", 256'(passed), 256'd63);
    tick();
    chk("sat_stick", 256'(passed), 256'd63);
    mask = 64'd0;
    for (int k = 0; k < 17; k++) begin
      tick();
    end
    chk("sat_drop_63", 256'(dropped), 256'd63);
    chk("sat_pass_hold", 256'(passed), 256'd63);
    drive(1'b0, 4'd0, 24'd0, 256'd0);
    tick();

    // Reset while output and skid are both full
    mask = 64'hFFFF_FFFF_FFFF_FFFF;
    m_ready = 1'b0;
    drive(1'b1, 4'b1111, ch4(1, 2, 3, 4), mk_time(700));
    tick(); tick();
    chk("mid_full_ready", 256'(s_ready), 256'd0);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 256'(m_valid), 256'd0);
    chk("mid_rst_ready", 256'(s_ready), 256'd0);
    chk("mid_rst_passed", 256'(passed), 256'd0);
    chk("mid_rst_dropped", 256'(dropped), 256'd0);
    chk("mid_rst_time", m_time, 256'd0);
    rst = 1'b0;
    m_ready = 1'b1;
    drive(1'b0, 4'd0, 24'd0, 256'd0);
    tick();
    chk("mid_ready_back", 256'(s_ready), 256'd1);
    chk("mid_valid_low", 256'(m_valid), 256'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
